// File: rtl/pp_accum_pkg.sv
// Shared constants, types and column-table helpers for the bit-serial
// partial-product column accumulator.
package pp_accum_pkg;

  localparam int unsigned BW     = 8;
  localparam int unsigned NCOL   = 2 * BW;
  localparam int unsigned HMAX   = BW / 2 + 2;
  localparam int unsigned CARRYW = $clog2(BW / 2 + 3);
  localparam int unsigned KW     = $clog2(NCOL);

  // Per-column count tables, indexed by column number.
  typedef logic [NCOL-1:0][7:0] cnt_tbl_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Populated rows in column k, clamped to the physical column height.
  function automatic int unsigned col_height(cnt_tbl_t pps, cnt_tbl_t plusone, int unsigned k);
    int unsigned s;
    s = 32'(pps[k[KW-1:0]]) + 32'(plusone[k[KW-1:0]]);
    return (s > HMAX) ? HMAX : s;
  endfunction

  function automatic logic [HMAX-1:0] col_mask(int unsigned h);
    return HMAX'((32'd1 << h) - 32'd1);
  endfunction

endpackage

// File: rtl/pp_col_popcount.sv
// Masked population count of one column plus the running carry; yields the
// product bit for this weight and the carry into the next column.
module pp_col_popcount
  import pp_accum_pkg::*;
(
  input  logic [HMAX-1:0]   col_i,
  input  logic [HMAX-1:0]   mask_i,
  input  logic [CARRYW-1:0] carry_i,
  output logic              sum_o,
  output logic [CARRYW-1:0] carry_o
);

  logic [CARRYW:0] total;

  always_comb begin
    total   = (CARRYW + 1)'($countones(col_i & mask_i)) + {1'b0, carry_i};
    sum_o   = total[0];
    carry_o = total[CARRYW:1];
  end

endmodule

// File: rtl/pp_column_accumulator.sv
// Bit-serial reducer for a column-ordered partial-product array: one column
// per cycle, LSB first, with a running carry; result is mod 2^(2*BW).
module pp_column_accumulator
  import pp_accum_pkg::*;
#(
  parameter cnt_tbl_t    PPS            = {NCOL{8'd5}},
  parameter cnt_tbl_t    PLUSONE        = {NCOL{8'd1}},
  parameter int unsigned LEASTSIGNIFCOL = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NCOL-1:0][HMAX-1:0] cols,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NCOL-1:0]           product,
  output logic                      busy
);

  if (LEASTSIGNIFCOL >= NCOL) begin : g_bad_lsc
    $error("LEASTSIGNIFCOL must be below 2*BW");
  end

  localparam logic [KW-1:0] KFirst = KW'(LEASTSIGNIFCOL);
  localparam logic [KW-1:0] KLast  = KW'(NCOL - 1);

  logic [NCOL-1:0][HMAX-1:0] mask_tbl;

  for (genvar k = 0; k < NCOL; k++) begin : g_mask
    assign mask_tbl[k] = col_mask(col_height(PPS, PLUSONE, k));
  end

  state_t                    state_q, state_d;
  logic [NCOL-1:0][HMAX-1:0] arr_q, arr_d;
  logic [KW-1:0]             k_q, k_d;
  logic [CARRYW-1:0]         carry_q, carry_d;
  logic [NCOL-1:0]           product_q, product_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, busy_d;

  logic                      col_sum;
  logic [CARRYW-1:0]         col_carry;

  pp_col_popcount u_popcount (
    .col_i   (arr_q[k_q]),
    .mask_i  (mask_tbl[k_q]),
    .carry_i (carry_q),
    .sum_o   (col_sum),
    .carry_o (col_carry)
  );

  always_comb begin
    state_d     = state_q;
    arr_d       = arr_q;
    k_d         = k_q;
    carry_d     = carry_q;
    product_d   = product_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Masking here keeps undriven rows from ever reaching the adder.
          arr_d      = cols & mask_tbl;
          k_d        = KFirst;
          carry_d    = '0;
          product_d  = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        product_d[k_q] = col_sum;
        if (k_q == KLast) begin
          // Carry out of the top column is the two's-complement wrap.
          carry_d     = '0;
          state_d     = DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          carry_d = col_carry;
          k_d     = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      arr_q       <= '0;
      k_q         <= '0;
      carry_q     <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      arr_q       <= arr_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

  carry_bound_a : assert property (@(posedge clk) disable iff (rst)
    carry_q <= CARRYW'(BW / 2 + 1));

endmodule

// File: tb/tb_pp_column_accumulator.sv
// Scoreboard bench: two accumulators (first column 0 and 4) sharing one
// non-uniform height table, checked against an arithmetic column-sum model.
module tb_pp_column_accumulator;
  import pp_accum_pkg::*;

  typedef logic [NCOL-1:0][HMAX-1:0] arr_t;
  typedef struct {
    logic [NCOL-1:0] prod;
    int unsigned     cyc;
  } exp_t;

  function automatic cnt_tbl_t mk_pps();
    cnt_tbl_t t;
    t     = {NCOL{8'd5}};
    t[5]  = 8'd1;
    t[7]  = 8'd7;
    t[9]  = 8'd0;
    t[12] = 8'd2;
    return t;
  endfunction

  function automatic cnt_tbl_t mk_plus();
    cnt_tbl_t t;
    t    = {NCOL{8'd1}};
    t[9] = 8'd0;
    return t;
  endfunction

  localparam cnt_tbl_t PpsT  = mk_pps();
  localparam cnt_tbl_t PlusT = mk_plus();

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid  [2];
  logic            in_ready  [2];
  arr_t            cols      [2];
  logic            out_valid [2];
  logic            out_ready [2];
  logic [NCOL-1:0] product   [2];
  logic            busy      [2];

  logic            rnd_bp;
  logic            rnd_or    [2];
  logic            or_force  [2];

  int unsigned     nvec = 0;
  int unsigned     nmis = 0;
  int unsigned     cyc  = 0;
  exp_t            q0[$];
  exp_t            q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign out_ready[g] = rnd_bp ? rnd_or[g] : or_force[g];
    pp_column_accumulator #(
      .PPS            (PpsT),
      .PLUSONE        (PlusT),
      .LEASTSIGNIFCOL ((g == 0) ? 0 : 4)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .cols      (cols[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .product   (product[g]),
      .busy      (busy[g])
    );
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) rnd_or[i] = 1'($urandom_range(0, 1));
  end

  function automatic int unsigned lsc_of(int i);
    return (i == 0) ? 0 : 4;
  endfunction

  // Product = sum over counted columns of (ones in the populated rows) * 2^k.
  function automatic logic [NCOL-1:0] ref_prod(arr_t c, int unsigned lsc);
    int unsigned acc = 0;
    for (int k = int'(lsc); k < int'(NCOL); k++) begin
      int h = int'(PpsT[k]) + int'(PlusT[k]);
      if (h > int'(HMAX)) h = int'(HMAX);
      for (int r = 0; r < h; r++) acc += 32'(c[k][r]) << k;
    end
    return acc[NCOL-1:0];
  endfunction

  function automatic arr_t rand_arr();
    arr_t c;
    for (int k = 0; k < int'(NCOL); k++) c[k] = HMAX'($urandom);
    return c;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(int i, logic [NCOL-1:0] e);
    exp_t x;
    x.prod = e;
    x.cyc  = cyc;
    if (i == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  task automatic send(int i, arr_t c, logic [NCOL-1:0] e);
    int n = 0;
    @(negedge clk);
    in_valid[i] = 1'b1;
    cols[i]     = c;
    while (in_ready[i] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (in_ready[i] !== 1'b1) begin
      nvec++;
      nmis++;
      $display("FAIL accept_timeout inst=%0d", i);
    end else begin
      push_exp(i, e);
    end
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    cols[i]     = rand_arr();
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      nvec++;
      nmis++;
      $display("FAIL drain_timeout pending=%0d/%0d", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // Monitor: first out_valid cycle pops and checks value and latency; later
  // cycles of the same output check that it is held and input stays blocked.
  logic            prev_ov [2];
  logic [NCOL-1:0] held    [2];
  always @(negedge clk) begin
    exp_t e;
    bit   empty;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        prev_ov[i] = 1'b0;
      end else begin
        if (out_valid[i] === 1'b1 && !prev_ov[i]) begin
          empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
          nvec++;
          if (empty) begin
            nmis++;
            $display("FAIL unexpected_output inst=%0d product=%h", i, product[i]);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            if (product[i] !== e.prod) begin
              nmis++;
              $display("FAIL product inst=%0d got %h expected %h", i, product[i], e.prod);
            end
            nvec++;
            if (cyc - e.cyc != NCOL - lsc_of(i) + 1) begin
              nmis++;
              $display("FAIL latency inst=%0d got %0d expected %0d", i, cyc - e.cyc,
                       NCOL - lsc_of(i) + 1);
            end
          end
          held[i] = product[i];
        end else if (out_valid[i] === 1'b1) begin
          nvec++;
          if (product[i] !== held[i] || in_ready[i] !== 1'b0) begin
            nmis++;
            $display("FAIL hold inst=%0d product=%h held=%h in_ready=%b", i, product[i],
                     held[i], in_ready[i]);
          end
        end
        prev_ov[i] = (out_valid[i] === 1'b1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arr_t a;
    arr_t b;
    int   n;
    rst    = 1'b1;
    rnd_bp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      cols[i]     = '0;
      or_force[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_in_ready", 32'(in_ready[i]), 32'd1);
      chk("reset_out_valid", 32'(out_valid[i]), 32'd0);
      chk("reset_busy", 32'(busy[i]), 32'd0);
      chk("reset_product", 32'(product[i]), 32'd0);
    end

    a = '0; a[0] = 6'b000001;                      send(0, a, 16'h0001);
    a = '0; a[3] = 6'b111111;                      send(0, a, 16'h0030);
    a = '0; a[15] = 6'b000011;                     send(0, a, 16'h0000);
    a = '0; a[5] = 6'b111111;                      send(0, a, 16'h0040);
    a = '0; a[5] = 6'b000011; a[5][5:2] = 'x; a[9] = 'x;
    a[12] = 6'b000101; a[12][5:3] = 'x; a[7] = 6'b111111;
    send(0, a, 16'h2340);
    a = '0; a[2] = 6'b000011; a[4] = 6'b000001;    send(1, a, 16'h0010);
    a = '0; a[15] = 6'b000001; a[0] = 6'b111111;   send(1, a, 16'h8000);
    drain();

    // Backpressure: result must stay put and a new array must be refused.
    or_force[0] = 1'b0;
    a = '0; a[1] = 6'b000101;
    send(0, a, 16'h0004);
    n = 0;
    while (out_valid[0] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 32'(out_valid[0]), 32'd1);
    b = '0; b[0] = 6'b000111;
    in_valid[0] = 1'b1;
    cols[0]     = b;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
      chk("bp_product", 32'(product[0]), 32'h0004);
    end
    or_force[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", 32'(out_valid[0]), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready[0]), 32'd1);
    push_exp(0, 16'h0003);
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    drain();

    // Reset in the seventh RUN cycle discards the array.
    a = '0; a[0] = 6'b111111; a[10] = 6'b000011;
    send(0, a, ref_prod(a, 0));
    repeat (6) @(posedge clk);
    #1;
    chk("run_busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrun_rst_in_ready", 32'(in_ready[0]), 32'd1);
    chk("midrun_rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("midrun_rst_product", 32'(product[0]), 32'd0);
    chk("midrun_rst_busy", 32'(busy[0]), 32'd0);
    send(0, '0, 16'h0000);
    drain();

    // Random arrays with random backpressure on both instances.
    rnd_bp = 1'b1;
    fork
      begin
        for (int t = 0; t < 25; t++) begin
          arr_t c = rand_arr();
          send(0, c, ref_prod(c, 0));
        end
      end
      begin
        for (int t = 0; t < 25; t++) begin
          arr_t c = rand_arr();
          send(1, c, ref_prod(c, 4));
        end
      end
    join
    drain();
    rnd_bp = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
